// File: rtl/vx_commit_arb_pkg.sv
// Shared definitions for the commit arbiter slice.
//
// Contents:
//   NUM_EX_UNITS  - number of execute units feeding one issue slot (ALU, LSU, FPU, SFU)
//   COMMIT_DATAW  - default width of one commit payload beat
//   commit_data_t - commit payload beat at the default width
//   arb_state_e   - arbiter lock state (open for round-robin, or locked to one unit)
//   sel_width()   - width of a unit index, never less than one bit
package vx_commit_arb_pkg;

    localparam int NUM_EX_UNITS = 4;
    localparam int COMMIT_DATAW = 64;

    typedef logic [COMMIT_DATAW-1:0] commit_data_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_commit_arb_rr_lock.sv
// vx_rr_lock_arb: round-robin grant with end-of-packet lock.
//
// Picks one requester per cycle, starting the search at the round-robin
// pointer. Once a non-eop beat is accepted the grant stays on that unit
// until its eop beat is accepted. The pointer only moves on an accepted eop
// beat, to one past the unit that finished.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   valid[N]    - per-unit request
//   eop[N]      - per-unit end-of-packet flag for the current beat
//   en          - downstream can take a beat this cycle
//   ready[N]    - per-unit accept, at most one bit set
//   accept      - a beat is transferred this cycle
//   grant_idx   - index of the granted unit
module vx_rr_lock_arb
    import vx_commit_arb_pkg::*;
#(
    parameter int N = NUM_EX_UNITS,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     valid,
    input  logic [N-1:0]     eop,
    input  logic             en,
    output logic [N-1:0]     ready,
    output logic             accept,
    output logic [SEL_W-1:0] grant_idx
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] rr_q, rr_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;

    // First valid requester at or after the pointer, wrapping N-1 -> 0.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!pick_found && valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(cand);
            end
        end
    end

    // Grant selection, lock tracking and pointer update.
    always_comb begin
        logic grant_any;
        state_d    = state_q;
        rr_d       = rr_q;
        lock_idx_d = lock_idx_q;
        grant_idx  = pick_idx;
        grant_any  = pick_found;
        ready      = '0;
        accept     = 1'b0;

        // A locked packet owns the grant even if other units are requesting.
        if (state_q == ARB_LOCKED) begin
            grant_idx = lock_idx_q;
            grant_any = 1'b1;
        end

        if (grant_any && en) begin
            ready[grant_idx] = 1'b1;
            accept           = valid[grant_idx];
        end

        if (accept) begin
            if (eop[grant_idx]) begin
                state_d = ARB_OPEN;
                rr_d    = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
            end else begin
                state_d    = ARB_LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_OPEN;
            rr_q       <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// vx_commit_arb: merges the per-unit commit streams of one issue slot into
// one registered commit stream for writeback / scoreboard release, and counts
// retired instructions for the CSR path.
//
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   in_valid     - per-unit beat valid            [NUM_INPUTS]
//   in_data      - per-unit payload, unit i at [i*DATAW +: DATAW]
//   in_eop       - per-unit last-beat flag        [NUM_INPUTS]
//   in_ready     - per-unit accept                [NUM_INPUTS]
//   out_valid    - merged beat valid
//   out_data     - merged payload                 [DATAW]
//   out_eop      - merged last-beat flag
//   out_sel      - source unit of the out beat
//   out_ready    - downstream accept
//   retired_cnt  - committed-instruction count    [CNT_W], wraps
//   stall_cnt    - per-unit saturating stall counters, 32 bits each
//                  (present only when VX_COMMIT_ARB_STATS_EN is defined)
//
// Build option: define VX_COMMIT_ARB_STATS_EN to add the stall counters.
module vx_commit_arb
    import vx_commit_arb_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_EX_UNITS,
    parameter int DATAW      = COMMIT_DATAW,
    parameter int CNT_W      = 64,
    localparam int SEL_W     = sel_width(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_eop,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic                        out_eop,
    output logic [SEL_W-1:0]            out_sel,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            retired_cnt
`ifdef VX_COMMIT_ARB_STATS_EN
    ,
    output logic [NUM_INPUTS*32-1:0]    stall_cnt
`endif
);

    logic             accept;
    logic [SEL_W-1:0] grant_idx;
    logic             not_full;
    logic             arb_en;

    // Two-entry output buffer: head drives the outputs, tail catches the
    // beat that arrives while the head is stalled.
    logic [1:0]       count_q, count_d;
    logic [DATAW-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic             head_eop_q, head_eop_d, tail_eop_q, tail_eop_d;
    logic [SEL_W-1:0] head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [DATAW-1:0] push_data;
    logic             push_eop;
    logic             pop;

    // Space is judged on occupancy alone, so in_ready never depends
    // combinationally on out_ready.
    assign not_full = (count_q != 2'd2);
    assign arb_en   = not_full && !reset;

    vx_rr_lock_arb #(
        .N(NUM_INPUTS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (in_valid),
        .eop       (in_eop),
        .en        (arb_en),
        .ready     (in_ready),
        .accept    (accept),
        .grant_idx (grant_idx)
    );

    assign out_valid   = (count_q != 2'd0);
    assign out_data    = head_data_q;
    assign out_eop     = head_eop_q;
    assign out_sel     = head_sel_q;
    assign retired_cnt = retired_q;
    assign pop         = out_valid && out_ready;

    always_comb begin
        push_data = in_data[int'(grant_idx)*DATAW +: DATAW];
        push_eop  = in_eop[grant_idx];
    end

    // Buffer occupancy and entry movement; a push during a pop with one
    // entry lands directly in the head so order is preserved.
    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_eop_d  = head_eop_q;
        head_sel_d  = head_sel_q;
        tail_data_d = tail_data_q;
        tail_eop_d  = tail_eop_q;
        tail_sel_d  = tail_sel_q;
        retired_d   = retired_q;

        unique case ({accept, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = push_data;
                    head_eop_d  = push_eop;
                    head_sel_d  = grant_idx;
                end else begin
                    tail_data_d = push_data;
                    tail_eop_d  = push_eop;
                    tail_sel_d  = grant_idx;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_eop_d  = tail_eop_q;
                head_sel_d  = tail_sel_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = push_data;
                    head_eop_d  = push_eop;
                    head_sel_d  = grant_idx;
                end else begin
                    head_data_d = tail_data_q;
                    head_eop_d  = tail_eop_q;
                    head_sel_d  = tail_sel_q;
                    tail_data_d = push_data;
                    tail_eop_d  = push_eop;
                    tail_sel_d  = grant_idx;
                end
            end
            default: begin
            end
        endcase

        if (pop && head_eop_q) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            head_data_q <= '0;
            head_eop_q  <= 1'b0;
            head_sel_q  <= '0;
            tail_data_q <= '0;
            tail_eop_q  <= 1'b0;
            tail_sel_q  <= '0;
            retired_q   <= '0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_eop_q  <= head_eop_d;
            head_sel_q  <= head_sel_d;
            tail_data_q <= tail_data_d;
            tail_eop_q  <= tail_eop_d;
            tail_sel_q  <= tail_sel_d;
            retired_q   <= retired_d;
        end
    end

`ifdef VX_COMMIT_ARB_STATS_EN
    logic [NUM_INPUTS*32-1:0] stall_q, stall_d;

    // Count cycles each unit waits with a beat pending; stick at all-ones.
    always_comb begin
        stall_d = stall_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_valid[i] && !in_ready[i] && (stall_q[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                stall_d[i*32 +: 32] = stall_q[i*32 +: 32] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb (4 inputs, 64-bit payload, 4-bit retired
// counter so the wrap is reachable). Beats carry {unit, sequence} so the
// scoreboard can spot loss, duplication or reordering.
module tb_vx_commit_arb;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int CW = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic          eop;
      logic [1:0]    sel;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_eop;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_eop;
   logic [1:0]      out_sel;
   logic            out_ready;
   logic [CW-1:0]   retired_cnt;
`ifdef VX_COMMIT_ARB_STATS_EN
   logic [N*32-1:0] stall_cnt;
`endif

   int    checks = 0;
   int    errors = 0;
   int    seq [N];
   beat_t sbQ [$];

   vx_commit_arb #(
      .NUM_INPUTS (N),
      .DATAW      (DW),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_eop      (in_eop),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_eop     (out_eop),
      .out_sel     (out_sel),
      .out_ready   (out_ready),
      .retired_cnt (retired_cnt)
`ifdef VX_COMMIT_ARB_STATS_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Guard against a hang; never reached in a healthy run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Payload of each unit is derived from its sequence number only, so a
   // held beat keeps stable data.
   task automatic refreshData();
      for (int u = 0; u < N; u++) begin
         in_data[u*DW +: DW] = {32'(u), 32'(seq[u])};
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] e, input logic ordy);
      in_valid  = v;
      in_eop    = e;
      out_ready = ordy;
      refreshData();
      #1;
   endtask

   // Record transfers on both sides, advance one clock, then move each
   // accepted unit on to its next beat.
   task automatic clockEdge();
      logic [N-1:0] acc;
      logic         popped;
      beat_t        b;
      acc    = in_valid & in_ready;
      popped = out_valid & out_ready;
      checkOutput("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
      if (popped) begin
         checks++;
         assert (sbQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL sb_pop_without_push: observed=%0d expected=nonzero", sbQ.size());
         end
         if (sbQ.size() > 0) begin
            b = sbQ.pop_front();
            checkOutput("sb_data", out_data, b.data);
            checkOutput("sb_eop", 64'(out_eop), 64'(b.eop));
            checkOutput("sb_sel", 64'(out_sel), 64'(b.sel));
         end
      end
      for (int u = 0; u < N; u++) begin
         if (acc[u]) begin
            b.data = in_data[u*DW +: DW];
            b.eop  = in_eop[u];
            b.sel  = 2'(u);
            sbQ.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      for (int u = 0; u < N; u++) begin
         if (acc[u]) seq[u]++;
      end
      refreshData();
   endtask

   int t2Rdy [5] = '{2, 2, 2, 4, 1};
   int t2Sel [5] = '{1, 1, 1, 2, 0};
   int t2Eop [5] = '{0, 0, 1, 1, 1};
   int t3Rdy [8] = '{2, 4, 0, 0, 0, 0, 8, 1};
   int t3Vld [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
   int t3Sel [8] = '{0, 1, 1, 1, 1, 1, 2, 3};
   int t4Eop [5] = '{0, 1, 1, 1, 1};
   int t4Ret [5] = '{12, 12, 12, 13, 14};

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_eop    = '0;
      in_data   = '0;
      out_ready = 1'b0;
      for (int u = 0; u < N; u++) seq[u] = 0;

      // Reset values, with every unit requesting
      @(posedge clk);
      #1;
      applyStimulus(4'hF, 4'hF, 1'b1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_eop", 64'(out_eop), 64'd0);
      checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
      checkOutput("rst_out_data", out_data, 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_retired", 64'(retired_cnt), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("rst_hold_out_valid", 64'(out_valid), 64'd0);
      reset = 1'b0;

      // Test 1: all units single-beat, round-robin 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'hF, 4'hF, 1'b1);
         checkOutput("t1_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
         if (k == 0) begin
            checkOutput("t1_first_out_valid", 64'(out_valid), 64'd0);
         end else begin
            checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
            checkOutput("t1_out_sel", 64'(out_sel), 64'((k - 1) % 4));
         end
         clockEdge();
      end
      applyStimulus(4'h0, 4'h0, 1'b1);
      checkOutput("t1_last_sel", 64'(out_sel), 64'd0);
      checkOutput("t1_retired_4", 64'(retired_cnt), 64'd4);
      clockEdge();
      checkOutput("t1_drained", 64'(out_valid), 64'd0);
      checkOutput("t1_retired_5", 64'(retired_cnt), 64'd5);

      // Test 2: unit 1 three-beat packet holds the grant over units 0 and 2
      for (int k = 0; k < 5; k++) begin
         applyStimulus({1'b0, 1'b1, 1'(k < 3), 1'b1}, {1'b0, 1'b1, 1'(k == 2), 1'b1}, 1'b1);
         checkOutput("t2_in_ready", 64'(in_ready), 64'(t2Rdy[k]));
         if (k > 0) begin
            checkOutput("t2_out_sel", 64'(out_sel), 64'(t2Sel[k-1]));
            checkOutput("t2_out_eop", 64'(out_eop), 64'(t2Eop[k-1]));
         end
         clockEdge();
      end
      applyStimulus(4'h0, 4'h0, 1'b1);
      checkOutput("t2_last_sel", 64'(out_sel), 64'd0);
      checkOutput("t2_retired_7", 64'(retired_cnt), 64'd7);
      clockEdge();
      checkOutput("t2_retired_8", 64'(retired_cnt), 64'd8);

      // Test 3: downstream stall fills exactly two entries, then drains in order
      for (int k = 0; k < 8; k++) begin
         applyStimulus(4'hF, 4'hF, 1'(k >= 5));
         checkOutput("t3_in_ready", 64'(in_ready), 64'(t3Rdy[k]));
         checkOutput("t3_out_valid", 64'(out_valid), 64'(t3Vld[k]));
         if (t3Vld[k] != 0) checkOutput("t3_out_sel", 64'(out_sel), 64'(t3Sel[k]));
         clockEdge();
      end
      applyStimulus(4'h0, 4'h0, 1'b1);
      checkOutput("t3_last_sel", 64'(out_sel), 64'd0);
      checkOutput("t3_retired_11", 64'(retired_cnt), 64'd11);
      clockEdge();
      checkOutput("t3_drained", 64'(out_valid), 64'd0);
      checkOutput("t3_retired_12", 64'(retired_cnt), 64'd12);

      // Test 4: non-eop beat leaves count alone, then the counter wraps
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1000, {1'(t4Eop[k]), 3'b000}, 1'b1);
         checkOutput("t4_in_ready", 64'(in_ready), 64'd8);
         checkOutput("t4_retired", 64'(retired_cnt), 64'(t4Ret[k]));
         if (k == 1) checkOutput("t4_non_eop_out", 64'(out_eop), 64'd0);
         clockEdge();
      end
      applyStimulus(4'h0, 4'h0, 1'b1);
      checkOutput("t4_retired_15", 64'(retired_cnt), 64'd15);
      clockEdge();
      checkOutput("t4_retired_wrap", 64'(retired_cnt), 64'd0);

      // Test 5: asynchronous reset mid-packet with two entries buffered
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      checkOutput("t5_in_ready_a", 64'(in_ready), 64'd1);
      clockEdge();
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checkOutput("t5_in_ready_b", 64'(in_ready), 64'd4);
      clockEdge();
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("t5_in_ready_c", 64'(in_ready), 64'd4);
      clockEdge();
      applyStimulus(4'b0110, 4'b0000, 1'b0);
      checkOutput("t5_full_in_ready", 64'(in_ready), 64'd0);
      checkOutput("t5_full_out_sel", 64'(out_sel), 64'd2);
      checkOutput("t5_pre_retired", 64'(retired_cnt), 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("t5_rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("t5_rst_retired", 64'(retired_cnt), 64'd0);
      checkOutput("t5_rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("t5_rst_out_data", out_data, 64'd0);
      sbQ.delete();
      applyStimulus(4'h0, 4'h0, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(4'hF, 4'hF, 1'b1);
      checkOutput("t5_grant_after_reset", 64'(in_ready), 64'd1);
      checkOutput("t5_empty_after_reset", 64'(out_valid), 64'd0);
      clockEdge();
      applyStimulus(4'hF, 4'hF, 1'b1);
      checkOutput("t5_next_in_ready", 64'(in_ready), 64'd2);
      checkOutput("t5_out_sel", 64'(out_sel), 64'd0);
      clockEdge();
      applyStimulus(4'h0, 4'h0, 1'b1);
      checkOutput("t5_out_sel_2", 64'(out_sel), 64'd1);
      clockEdge();
      checkOutput("t5_retired_2", 64'(retired_cnt), 64'd2);

`ifdef VX_COMMIT_ARB_STATS_EN
      // Stall counters: unit 3 waits 10 cycles behind unit 0's long packet
      reset = 1'b1;
      applyStimulus(4'h0, 4'h0, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sbQ.delete();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(4'b1001, 4'b0000, 1'b1);
         checkOutput("st_in_ready", 64'(in_ready), 64'd1);
         clockEdge();
      end
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      for (int i = 0; i < N; i++) begin
         checkOutput("st_stall_cnt", 64'(stall_cnt[i*32 +: 32]), (i == 3) ? 64'd10 : 64'd0);
      end
      clockEdge();
      applyStimulus(4'h0, 4'h0, 1'b1);
      clockEdge();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
